// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, widths and the
// buffered {pc, inst} entry.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo_mem.sv
// Entry storage for the fetch queue: DEPTH x {pc, inst} registers with wrapping
// read/write pointers and an occupancy counter. Flush empties it in one edge.
module fq_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fq_entry_t              i_wdata,
    output fq_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    fq_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, issues words to a 1-cycle imem and
// buffers responses for IF/ID. Macro FETCH_QUEUE_BYPASS_EN adds a same-cycle bypass.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0,
    parameter int              PC_STEP  = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [PC_W-1:0]        imem_addr,
    output logic                   imem_req,
    input  logic [INST_W-1:0]      imem_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_W-1:0]      inst_out,
    output logic [PC_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0] occupancy,
    output fq_state_t              dbg_state
);
    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t       r_state;
    fq_state_t       w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_inflight;
    logic            r_kill;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    fq_entry_t       w_head;
    fq_entry_t       w_wdata;
    logic            w_resp;
    logic            w_pop;
    logic            w_fifo_pop;
    logic            w_push;
    logic            w_credit_ok;

    // Handshake: an instruction transfers on a cycle where inst_valid && inst_ready;
    // inst_out/inst_pc are held steady while inst_valid is high and inst_ready is low.
    assign w_resp      = r_inflight && !r_kill;
    assign w_pop       = inst_valid && inst_ready;
    assign w_used      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit_ok = w_used < ((CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop});
    assign w_wdata     = '{pc: r_pend_pc, inst: imem_data};
    assign w_fifo_pop  = w_pop && (w_count != '0) && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = w_resp && (w_count == '0);
    assign w_push     = w_resp && !redirect && !(w_bypass && inst_ready);
    assign inst_valid = w_bypass || (w_count != '0);
    assign inst_out   = w_bypass ? imem_data : ((w_count != '0) ? w_head.inst : '0);
    assign inst_pc    = w_bypass ? r_pend_pc : ((w_count != '0) ? w_head.pc : '0);
`else
    assign w_push     = w_resp && !redirect;
    assign inst_valid = (w_count != '0);
    assign inst_out   = inst_valid ? w_head.inst : '0;
    assign inst_pc    = inst_valid ? w_head.pc : '0;
`endif

    fq_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_fifo_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                imem_req = w_credit_ok;
                if (!w_credit_ok) w_state_nxt = FULL;
            end
            FULL: if (w_pop) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
        if (redirect) w_state_nxt = RUN;
    end

    // A request issued in the redirect cycle still returns next cycle; r_kill drops it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= imem_req;
            r_kill     <= redirect;
            if (imem_req) r_pend_pc <= r_fetch_pc;
            if (redirect)      r_fetch_pc <= redirect_pc;
            else if (imem_req) r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
        end
    end

    assign imem_addr = r_fetch_pc;
    assign occupancy = w_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, redirect/kill, wrap, stall and async reset.
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;
  fq_state_t   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic found;

  fetch_queue dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .occupancy   (occupancy),
    .dbg_state   (dbg_state)
  );

  // clock / reset, plus an imem model returning addr + 0x100 one cycle after a request
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) imem_data <= 32'h0;
    else if (imem_req) imem_data <= imem_addr + 32'h100;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  // driver / checker tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
  endtask

  // scoreboard: every accepted instruction must be the next expected PC
  task automatic sb_pop();
    logic [31:0] e;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed=pc %h expected=no delivery", inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_inst", inst_out, e + 32'h100);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'(0));
    chk({tag, "_valid"}, 32'(inst_valid), 32'(0));
    chk({tag, "_out"}, inst_out, 32'h0);
    chk({tag, "_pc"}, inst_pc, 32'h0);
    chk({tag, "_occ"}, 32'(occupancy), 32'(0));
    chk({tag, "_state"}, 32'(dbg_state), 32'(BOOT));
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'(0));
    chk("boot_state", 32'(dbg_state), 32'(BOOT));

    // stream from RESET_PC; redirect to 0x40 while address 5 is being fetched
    fill(32'h0, 16);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) begin
        redirect = 1'b1;
        redirect_pc = 32'h40;
      end
      #1;
      chk("stream_req", 32'(imem_req), 32'(1));
      chk("stream_addr", imem_addr, 32'(c - 1));
      chk("stream_valid", 32'(inst_valid), 32'(c >= LAT));
      sb_pop();
    end
    exp_q.delete();
    fill(32'h40, 16);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_occ", 32'(occupancy), 32'(0));
    chk("redir_valid0", 32'(inst_valid), 32'(0));
    chk("redir_req", 32'(imem_req), 32'(1));
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_state", 32'(dbg_state), 32'(RUN));
    for (int c = 8; c <= 12; c++) begin
      tick();
      #1;
      chk("redir_valid", 32'(inst_valid), 32'(c >= 6 + LAT));
      sb_pop();
    end

    // back-to-back redirects: only the second target is delivered
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h10;
    #1;
    sb_pop();
    exp_q.delete();
    fill(32'h10, 4);
    tick();
    redirect_pc = 32'h20;
    #1;
    sb_pop();
    exp_q.delete();
    fill(32'h20, 16);
    tick();
    redirect = 1'b0;
    #1;
    chk("dbl_occ", 32'(occupancy), 32'(0));
    chk("dbl_addr", imem_addr, 32'h20);
    chk("dbl_valid0", 32'(inst_valid), 32'(0));
    for (int k = 2; k <= 6; k++) begin
      tick();
      #1;
      chk("dbl_valid", 32'(inst_valid), 32'(k >= LAT));
      sb_pop();
    end

    // fetch PC wraps past 0xFFFFFFFF
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    #1;
    sb_pop();
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFF);
    fill(32'h0, 16);
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFF);
    sb_pop();
    tick();
    #1;
    chk("wrap_addr_lo", imem_addr, 32'h0);
    sb_pop();
    repeat (4) begin
      tick();
      #1;
      chk("wrap_valid", 32'(inst_valid), 32'(1));
      sb_pop();
    end

    // stall until three entries are buffered, then reset asynchronously mid-cycle
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      inst_ready = 1'b0;
      #1;
      if (occupancy == 3'd3) found = 1'b1;
    end
    chk("occ3_reached", 32'(found), 32'(1));
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    inst_ready = 1'b1;
    exp_q.delete();
    fill(32'h0, 16);
    #1;
    chk("reboot_req", 32'(imem_req), 32'(0));

    // restart from RESET_PC, then hold IF/ID stalled from the first valid cycle
    for (int c = 1; c <= LAT + 10; c++) begin
      tick();
      inst_ready = (c < LAT);
      #1;
      if (c == 1) chk("restart_addr", imem_addr, 32'h0);
      chk("restart_valid", 32'(inst_valid), 32'(c >= LAT));
      if (c >= LAT) begin
        chk("stall_head_pc", inst_pc, 32'h0);
        chk("stall_head_inst", inst_out, 32'h100);
      end
      sb_pop();
    end
    chk("stall_occ", 32'(occupancy), 32'(4));
    chk("stall_req", 32'(imem_req), 32'(0));
    chk("stall_state", 32'(dbg_state), 32'(FULL));

    // release: in-order delivery with no gaps or duplicates
    for (int k = 0; k < 8; k++) begin
      tick();
      inst_ready = 1'b1;
      #1;
      chk("release_valid", 32'(inst_valid), 32'(1));
      sb_pop();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
